// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between four byte requesters.
// Define UART_ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 highest) instead of round-robin.
module uart_tx_arbiter #(
    parameter int BUSY_TIMEOUT = 16384,
    parameter int TO_W         = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  ack,
    output logic [1:0]  grant_id,
    output logic        active,
    output logic        timeout_err,
    output logic [7:0]  Tx_DATA,
    output logic        Tx_WR,
    output logic        Tx_EN,
    input  logic        Tx_BUSY
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        WAIT_START,
        WAIT_END,
        GAP
    } state_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [3:0]      ack_q, ack_d;
    logic [1:0]      grant_id_q, grant_id_d;
    logic            tx_en_q, tx_en_d;
    logic            tx_wr_q, tx_wr_d;
    logic            timeout_err_q, timeout_err_d;
    logic [1:0]      win;

`ifdef UART_ARB_FIXED_PRIORITY_EN
    always_comb begin
        win = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) win = 2'(i);
        end
    end
`else
    logic [1:0] ptr_q, ptr_d;

    // Scan from the farthest offset down so the nearest requester after ptr wins.
    always_comb begin
        win = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
        end
    end
`endif

    always_comb begin
        // NOTE: every _d starts from its hold value (or its idle pulse value) so no path infers a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        tx_data_d     = tx_data_q;
        grant_id_d    = grant_id_q;
        tx_en_d       = tx_en_q;
        ack_d         = 4'b0000;
        tx_wr_d       = 1'b0;
        timeout_err_d = 1'b0;
`ifndef UART_ARB_FIXED_PRIORITY_EN
        ptr_d         = ptr_q;
`endif

        case (state_q)
            IDLE: begin
                if (|req) begin
                    tx_data_d  = req_data[{win, 3'b000} +: 8];
                    ack_d      = 4'b0001 << win;
                    grant_id_d = win;
                    tx_en_d    = 1'b1;
`ifndef UART_ARB_FIXED_PRIORITY_EN
                    ptr_d      = win + 2'd1;
`endif
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                tx_wr_d = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                cnt_d   = '0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (Tx_BUSY) begin
                    state_d = WAIT_END;
                end else if (cnt_q == TO_W'(BUSY_TIMEOUT - 1)) begin
                    // The transmitter never accepted the frame; give up and free the bus.
                    timeout_err_d = 1'b1;
                    tx_en_d       = 1'b0;
                    state_d       = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_END: begin
                if (!Tx_BUSY) begin
                    tx_en_d = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            tx_data_q     <= 8'h00;
            ack_q         <= 4'b0000;
            grant_id_q    <= 2'd0;
            tx_en_q       <= 1'b0;
            tx_wr_q       <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tx_data_q     <= tx_data_d;
            ack_q         <= ack_d;
            grant_id_q    <= grant_id_d;
            tx_en_q       <= tx_en_d;
            tx_wr_q       <= tx_wr_d;
            timeout_err_q <= timeout_err_d;
        end
    end

`ifndef UART_ARB_FIXED_PRIORITY_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign ack         = ack_q;
    assign grant_id    = grant_id_q;
    assign active      = (state_q != IDLE);
    assign timeout_err = timeout_err_q;
    assign Tx_DATA     = tx_data_q;
    assign Tx_WR       = tx_wr_q;
    assign Tx_EN       = tx_en_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: timestamp-based frame model plus directed scenarios.
// A small transmitter model drives Tx_BUSY with configurable behaviour.
module tb_uart_tx_arbiter;

    localparam int T   = 8;
    localparam int INF = 1 << 30;
`ifdef UART_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [1:0]  grant_id;
    logic        active;
    logic        timeout_err;
    logic [7:0]  Tx_DATA;
    logic        Tx_WR;
    logic        Tx_EN;
    logic        Tx_BUSY;

    always #5 clock = ~clock;

    uart_tx_arbiter #(.BUSY_TIMEOUT(T), .TO_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .grant_id   (grant_id),
        .active     (active),
        .timeout_err(timeout_err),
        .Tx_DATA    (Tx_DATA),
        .Tx_WR      (Tx_WR),
        .Tx_EN      (Tx_EN),
        .Tx_BUSY    (Tx_BUSY)
    );

    // Transmitter: mode 0 never busy, 1 busy for xlen cycles after the write,
    // 2 busy already during the write cycle and xlen cycles in total.
    int xmode = 0;
    int xlen  = 0;
    int busy_cnt;

    always @(posedge clock or posedge reset) begin
        if (reset) busy_cnt <= 0;
        else if (Tx_WR && xmode != 0) busy_cnt <= (xmode == 2) ? xlen - 1 : xlen;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    assign Tx_BUSY = (busy_cnt > 0) || (xmode == 2 && Tx_WR);

    // Frame model: each frame is a set of timestamps (ack cycle, first wait cycle, gap cycle).
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic int pick(logic [3:0] r, int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    logic       m_frame;
    logic       m_to;
    int         m_ptr, m_g, m_ws, m_rise, m_gap;
    logic [7:0] m_data;
    logic [1:0] m_gid;
    int         m_pick;

    always_comb m_pick = pick(req, FIXED ? 0 : m_ptr);

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_frame <= 1'b0;
            m_to    <= 1'b0;
            m_ptr   <= 0;
            m_g     <= 0;
            m_ws    <= 0;
            m_rise  <= -1;
            m_gap   <= 0;
            m_data  <= 8'h00;
            m_gid   <= 2'd0;
        end else if (!m_frame || cyc > m_gap) begin
            if (m_pick >= 0) begin
                m_frame <= 1'b1;
                m_to    <= 1'b0;
                m_g     <= cyc + 1;
                m_ws    <= cyc + 3;
                m_rise  <= -1;
                m_gap   <= INF;
                m_data  <= req_data[8*m_pick +: 8];
                m_gid   <= 2'(m_pick);
                m_ptr   <= (m_pick + 1) % 4;
            end
        end else if (m_gap == INF) begin
            if (m_rise < 0) begin
                if (cyc >= m_ws) begin
                    if (Tx_BUSY) m_rise <= cyc;
                    else if (cyc - m_ws + 1 == T) begin
                        m_gap <= cyc + 1;
                        m_to  <= 1'b1;
                    end
                end
            end else if (cyc > m_rise && !Tx_BUSY) begin
                m_gap <= cyc + 1;
            end
        end
    end

    int checks   = 0;
    int failures = 0;
    int wr_run, wr_max, wr_pulses, data_chg;
    logic prev_wr, prev_en;
    logic [7:0] prev_data;

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, expv, cyc);
        end
    endtask

    task automatic compare_cycle();
        logic in_frame = m_frame && cyc >= m_g && cyc <= m_gap;
        check("active", active, in_frame);
        check("ack", ack, (m_frame && cyc == m_g) ? (32'd1 << m_gid) : 32'd0);
        check("tx_wr", Tx_WR, m_frame && cyc == m_g + 1);
        check("tx_en", Tx_EN, m_frame && cyc >= m_g && cyc < m_gap);
        check("timeout_err", timeout_err, m_frame && m_to && cyc == m_gap);
        check("tx_data", Tx_DATA, m_data);
        check("grant_id", grant_id, m_gid);
        wr_run = Tx_WR ? wr_run + 1 : 0;
        if (wr_run > wr_max) wr_max = wr_run;
        if (Tx_WR && !prev_wr) wr_pulses++;
        if (Tx_EN && prev_en && Tx_DATA != prev_data) data_chg++;
        prev_wr   = Tx_WR;
        prev_en   = Tx_EN;
        prev_data = Tx_DATA;
    endtask

    task automatic step();
        @(negedge clock);
        compare_cycle();
    endtask

    task automatic steps(int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req      = 4'b0000;
        req_data = 32'h0;
        steps(2);
        reset = 1'b0;
        step();
    endtask

    task automatic wait_ack(output logic [1:0] gid, output logic [7:0] data);
        int k = 0;
        step();
        while (ack == 4'b0000 && k < 200) begin
            step();
            k++;
        end
        check("ack_seen", ack != 4'b0000, 1);
        gid  = grant_id;
        data = Tx_DATA;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (active && k < 300) begin
            step();
            k++;
        end
        check("idle_reached", active, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "bench did not terminate");
    end

    initial begin
        logic [1:0] g;
        logic [7:0] d;
        int n, k, wr_c;
        int order [5];
        wr_run = 0; wr_max = 0; wr_pulses = 0; data_chg = 0;
        prev_wr = 1'b0; prev_en = 1'b0; prev_data = 8'h00;
        reset = 1'b1;
        req = 4'b0000;
        req_data = 32'h0;

        // Single request on lane 2
        do_reset();
        check("t1_reset_outputs", {ack, grant_id, active, timeout_err, Tx_DATA, Tx_WR, Tx_EN}, 0);
        xmode = 1; xlen = 5;
        req_data = 32'h00A5_0000;
        req = 4'b0100;
        step();
        check("t1_ack", ack, 4'b0100);
        check("t1_data", Tx_DATA, 8'hA5);
        check("t1_gid", grant_id, 2);
        req = 4'b0000;
        step();
        check("t1_wr", Tx_WR, 1);
        n = 2;
        step();
        while (active && n < 100) begin
            n++;
            step();
        end
        check("t1_active_len", n, 9);

        // All four requesting continuously
        do_reset();
        xmode = 1; xlen = 20;
        req_data = 32'h4433_2211;
        req = 4'b1111;
        if (FIXED) order = '{0, 0, 0, 0, 0};
        else       order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            wait_ack(g, d);
            check("t2_order", g, order[i]);
            check("t2_data", d, 8'(8'h11 * (order[i] + 1)));
        end
        req = 4'b0000;
        wait_idle();

        // Transmitter never goes busy
        do_reset();
        xmode = 0;
        req_data = 32'h0000_005A;
        req = 4'b0001;
        wait_ack(g, d);
        req = 4'b0000;
        step();
        check("t3_wr", Tx_WR, 1);
        wr_c = cyc;
        k = 0;
        while (!timeout_err && k < 50) begin
            step();
            k++;
        end
        check("t3_timeout_delay", cyc - (wr_c + 1), 8);
        check("t3_gap_state", {active, Tx_EN}, 2'b10);
        wait_idle();
        xmode = 1; xlen = 3;
        req_data = 32'hC300_0000;
        req = 4'b1000;
        wait_ack(g, d);
        check("t3_next_gid", g, 3);
        check("t3_next_data", d, 8'hC3);
        req = 4'b0000;
        wait_idle();

        // Reset while waiting for the frame to end
        do_reset();
        xmode = 1; xlen = 30;
        req_data = 32'h0077_0000;
        req = 4'b0100;
        wait_ack(g, d);
        req = 4'b0000;
        steps(6);
        check("t4_in_frame", {active, Tx_EN}, 2'b11);
        #1 reset = 1'b1;
        #1;
        check("t4_reset_outputs", {ack, grant_id, active, timeout_err, Tx_DATA, Tx_WR, Tx_EN}, 0);
        steps(2);
        reset = 1'b0;
        req_data = 32'hB300_B100;
        req = 4'b1010;
        wait_ack(g, d);
        check("t4_ptr_restart_gid", g, 1);
        check("t4_ptr_restart_data", d, 8'hB1);
        req = 4'b0000;
        wait_idle();
        req_data = 32'h0000_2200;
        req = 4'b0010;
        wait_ack(g, d);
        check("t4_single_gid", g, 1);
        check("t4_single_data", d, 8'h22);
        req = 4'b0000;
        wait_idle();

        // Busy rises together with the write strobe
        do_reset();
        xmode = 2; xlen = 6;
        wr_max = 0; wr_pulses = 0; data_chg = 0;
        req_data = 32'h0000_00E7;
        req = 4'b0001;
        wait_ack(g, d);
        req = 4'b0000;
        n = 1;
        step();
        while (active && n < 100) begin
            n++;
            step();
        end
        check("t5_active_len", n, 9);
        check("t5_wr_max_run", wr_max, 1);
        check("t5_wr_pulses", wr_pulses, 1);
        check("t5_data_stable", data_chg, 0);
        check("t5_data_held", Tx_DATA, 8'hE7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
